// File: rtl/vout_timing.sv
// Output video timing generator, phase-locked to input vsync with a DELAY_LINES line lag.
// Optional macro VOUT_TIMING_FREERUN_EN keeps timing running (unlocked) after an input timeout.
module vout_timing #(
  parameter int unsigned H_WIDTH     = 1920,
  parameter int unsigned H_START     = 2008,
  parameter int unsigned H_SYNC      = 44,
  parameter int unsigned H_TOTAL     = 2200,
  parameter int unsigned V_HEIGHT    = 1080,
  parameter int unsigned V_START     = 1084,
  parameter int unsigned V_SYNC      = 5,
  parameter int unsigned V_TOTAL     = 1125,
  parameter int unsigned DELAY_LINES = 2
) (
  input  logic                       vin_clk_i,
  input  logic                       rst_ni,
  input  logic                       vin_vs_i,
  output logic                       vout_hs_o,
  output logic                       vout_vs_o,
  output logic                       vout_de_o,
  output logic [$clog2(H_TOTAL)-1:0] h_cnt_o,
  output logic [$clog2(V_TOTAL)-1:0] v_cnt_o,
  output logic                       locked_o,
  output logic                       resync_o
);

  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned DLY_LOAD = DELAY_LINES * H_TOTAL - 1;
  localparam int unsigned DW       = $clog2(DELAY_LINES * H_TOTAL + 1);
  localparam int unsigned TO_LIMIT = 2 * V_TOTAL * H_TOTAL;
  localparam int unsigned TW       = $clog2(TO_LIMIT + 1);

  typedef enum logic [1:0] {StWaitVs, StDelay, StRun} state_e;

  state_e        r_state, w_state_d;
  logic          r_vs_prev;
  logic [DW-1:0] r_dly_cnt, w_dly_cnt_d;
  logic [TW-1:0] r_to_cnt, w_to_cnt_d;
  logic [HW-1:0] r_h, w_h_d, w_h_nat;
  logic [VW-1:0] r_v, w_v_d, w_v_nat;
  logic          r_hs, w_hs_d;
  logic          r_vs, w_vs_d;
  logic          r_de, w_de_d;
  logic          r_locked, w_locked_d;
  logic          r_resync, w_resync_d;

  logic          w_vs_rise;
  logic          w_expire;
  logic          w_timeout;
  logic          w_run_d;
  logic [31:0]   w_h_ext;
  logic [31:0]   w_v_ext;

  assign w_vs_rise = vin_vs_i & ~r_vs_prev;
  // A reload on the same edge as the 1->0 step wins, so expire is masked by vs_rise.
  assign w_expire  = (r_dly_cnt == DW'(1)) & ~w_vs_rise;
  assign w_timeout = (r_to_cnt == TW'(TO_LIMIT - 1)) & ~w_vs_rise;

  always_comb begin
    w_dly_cnt_d = r_dly_cnt;
    if (w_vs_rise) begin
      w_dly_cnt_d = DW'(DLY_LOAD);
    end else if (r_dly_cnt != '0) begin
      w_dly_cnt_d = r_dly_cnt - DW'(1);
    end
  end

  // Saturates at the limit so the timeout event fires once per input loss.
  always_comb begin
    w_to_cnt_d = r_to_cnt;
    if (w_vs_rise) begin
      w_to_cnt_d = '0;
    end else if (r_to_cnt != TW'(TO_LIMIT)) begin
      w_to_cnt_d = r_to_cnt + TW'(1);
    end
  end

  always_comb begin
    w_h_nat = r_h + HW'(1);
    w_v_nat = r_v;
    if (r_h == HW'(H_TOTAL - 1)) begin
      w_h_nat = '0;
      w_v_nat = (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + VW'(1);
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_h_d      = '0;
    w_v_d      = '0;
    w_locked_d = r_locked;
    w_resync_d = 1'b0;
    unique case (r_state)
      StWaitVs: begin
        w_locked_d = 1'b0;
        if (w_vs_rise) w_state_d = StDelay;
      end
      StDelay: begin
        w_locked_d = 1'b0;
        if (w_expire) begin
          w_state_d  = StRun;
          w_h_d      = HW'(H_START);
          w_v_d      = VW'(V_START);
          w_locked_d = 1'b1;
        end
      end
      StRun: begin
        w_h_d = w_h_nat;
        w_v_d = w_v_nat;
        if (w_expire) begin
          w_locked_d = 1'b1;
          if ((w_h_nat != HW'(H_START)) || (w_v_nat != VW'(V_START))) begin
            w_h_d      = HW'(H_START);
            w_v_d      = VW'(V_START);
            w_resync_d = 1'b1;
          end
        end else if (w_timeout) begin
          w_locked_d = 1'b0;
`ifdef VOUT_TIMING_FREERUN_EN
          w_state_d  = StRun;
`else
          w_state_d  = StWaitVs;
          w_h_d      = '0;
          w_v_d      = '0;
`endif
        end
      end
      default: begin
        w_state_d  = StWaitVs;
        w_locked_d = 1'b0;
      end
    endcase
  end

  // Sync/DE decode from next-state counters so registered outputs match h/v in the same cycle.
  assign w_run_d = (w_state_d == StRun);
  assign w_h_ext = 32'(w_h_d);
  assign w_v_ext = 32'(w_v_d);

  always_comb begin
    w_hs_d = w_run_d && (w_h_ext >= H_START) && (w_h_ext < H_START + H_SYNC);
    w_vs_d = w_run_d && (w_v_ext >= V_START) && (w_v_ext < V_START + V_SYNC);
    w_de_d = w_run_d && (w_h_ext < H_WIDTH) && (w_v_ext < V_HEIGHT);
  end

  always_ff @(posedge vin_clk_i) begin
    if (!rst_ni) begin
      r_state   <= StWaitVs;
      r_vs_prev <= 1'b1;
      r_dly_cnt <= '0;
      r_to_cnt  <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_de      <= 1'b0;
      r_locked  <= 1'b0;
      r_resync  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_vs_prev <= vin_vs_i;
      r_dly_cnt <= w_dly_cnt_d;
      r_to_cnt  <= w_to_cnt_d;
      r_h       <= w_h_d;
      r_v       <= w_v_d;
      r_hs      <= w_hs_d;
      r_vs      <= w_vs_d;
      r_de      <= w_de_d;
      r_locked  <= w_locked_d;
      r_resync  <= w_resync_d;
    end
  end

  assign vout_hs_o = r_hs;
  assign vout_vs_o = r_vs;
  assign vout_de_o = r_de;
  assign h_cnt_o   = r_h;
  assign v_cnt_o   = r_v;
  assign locked_o  = r_locked;
  assign resync_o  = r_resync;

endmodule
